alu_op_sequencer: RTL

//  Multi-cycle control sequencer for the shared-bus datapath ALU (Y -> ALU -> Z, HI/LO).

---
 rtl/alu_op_sequencer_pkg.sv | 35 +++
 rtl/alu_op_decode.sv | 26 ++
 rtl/alu_op_sequencer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_pkg.sv
// Shared opcode encodings, sequencer state encoding and opcode class bundle
// for the shared-bus ALU op sequencer.
package alu_op_sequencer_pkg;

  localparam logic [4:0] OP_ADD  = 5'h03;
  localparam logic [4:0] OP_SUB  = 5'h04;
  localparam logic [4:0] OP_AND  = 5'h05;
  localparam logic [4:0] OP_OR   = 5'h06;
  localparam logic [4:0] OP_SHR  = 5'h07;
  localparam logic [4:0] OP_SHRA = 5'h08;
  localparam logic [4:0] OP_SHL  = 5'h09;
  localparam logic [4:0] OP_ROR  = 5'h0A;
  localparam logic [4:0] OP_ROL  = 5'h0B;
  localparam logic [4:0] OP_MUL  = 5'h0F;
  localparam logic [4:0] OP_DIV  = 5'h10;
  localparam logic [4:0] OP_NEG  = 5'h11;
  localparam logic [4:0] OP_NOT  = 5'h12;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_Y,
    S_EXEC,
    S_WAIT,
    S_WB_LO,
    S_WB_HI,
    S_DONE
  } state_t;

  typedef struct packed {
    logic legal;
    logic unary;
    logic muldiv;
  } op_class_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode classifier: legal / unary / multiply-divide.
module alu_op_decode
  import alu_op_sequencer_pkg::*;
(
  input  logic [4:0] opcode,
  output op_class_t  cls
);

  always_comb begin
    cls = '0;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL:
        cls.legal = 1'b1;
      OP_MUL, OP_DIV: begin
        cls.legal  = 1'b1;
        cls.muldiv = 1'b1;
      end
      OP_NEG, OP_NOT: begin
        cls.legal = 1'b1;
        cls.unary = 1'b1;
      end
      default: cls = '0;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle control sequencer for the Y -> ALU -> Z (HI/LO) shared-bus datapath.
// Moore outputs decoded from state and captured request fields.
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int MULDIV_WAIT = 2,
  parameter int REG_AW      = 4
) (
  input  logic              clk,
  input  logic              clear_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [4:0]        req_opcode,
  input  logic [REG_AW-1:0] req_ra,
  input  logic [REG_AW-1:0] req_rb,
  input  logic [REG_AW-1:0] req_rc,
  input  logic              b_is_zero,
  output logic [REG_AW-1:0] reg_sel,
  output logic              reg_out,
  output logic              reg_in,
  output logic              y_in,
  output logic              z_in,
  output logic              zlo_out,
  output logic              zhi_out,
  output logic              lo_in,
  output logic              hi_in,
  output logic [4:0]        alu_op,
  output logic              done,
  output logic              err
);

  state_t            state;
  logic [3:0]        cnt;
  logic [4:0]        op_q;
  logic [REG_AW-1:0] ra_q, rb_q, rc_q;
  logic              md_q;
  logic              err_q;
  op_class_t         cls;

  alu_op_decode u_dec (
    .opcode (req_opcode),
    .cls    (cls)
  );

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      op_q  <= '0;
      ra_q  <= '0;
      rb_q  <= '0;
      rc_q  <= '0;
      md_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          op_q  <= req_opcode;
          ra_q  <= req_ra;
          rb_q  <= req_rb;
          rc_q  <= req_rc;
          md_q  <= cls.muldiv;
          err_q <= ~cls.legal;
          if (!cls.legal)     state <= S_DONE;
          else if (cls.unary) state <= S_EXEC;
          else                state <= S_LOAD_Y;
        end
        S_LOAD_Y: state <= S_EXEC;
        S_EXEC: begin
          if (!md_q) begin
            state <= S_WB_LO;
          end else if (op_q == OP_DIV && b_is_zero) begin
            // Divide-by-zero: nothing reaches Z, report and finish.
            err_q <= 1'b1;
            state <= S_DONE;
          end else begin
            cnt   <= 4'(MULDIV_WAIT);
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= S_WB_LO;
        end
        S_WB_LO: state <= md_q ? S_WB_HI : S_DONE;
        S_WB_HI: state <= S_DONE;
        S_DONE: begin
          err_q <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    reg_sel = '0;
    reg_out = 1'b0;
    reg_in  = 1'b0;
    y_in    = 1'b0;
    z_in    = 1'b0;
    zlo_out = 1'b0;
    zhi_out = 1'b0;
    lo_in   = 1'b0;
    hi_in   = 1'b0;
    alu_op  = '0;
    done    = 1'b0;
    case (state)
      S_LOAD_Y: begin
        reg_sel = rb_q;
        reg_out = 1'b1;
        y_in    = 1'b1;
      end
      S_EXEC: begin
        reg_sel = rc_q;
        reg_out = 1'b1;
        alu_op  = op_q;
        z_in    = ~md_q;
      end
      S_WAIT: begin
        // Operand B stays on the bus for the whole multicycle window.
        reg_sel = rc_q;
        reg_out = 1'b1;
        alu_op  = op_q;
        z_in    = (cnt == 4'd1);
      end
      S_WB_LO: begin
        zlo_out = 1'b1;
        if (md_q) begin
          lo_in = 1'b1;
        end else begin
          reg_sel = ra_q;
          reg_in  = 1'b1;
        end
      end
      S_WB_HI: begin
        zhi_out = 1'b1;
        hi_in   = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign req_ready = (state == S_IDLE);
  assign err       = err_q;

endmodule
